ret_predict_ctrl: RTL and testbench

RET_PREDICT_CTRL -- requirements
Module: ret_predict_ctrl

---
 rtl/ras_pkg.sv | 13 +
 rtl/pred_fifo.sv | 74 +++++++
 rtl/ret_predict_ctrl.sv | 139 +++++++++++++
 tb/tb_ret_predict_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared defaults and FSM state type for the return-address prediction controller.
package ras_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned QDEPTH_DEF     = 4;
    localparam int unsigned RET_OFFSET_DEF = 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: circular buffer with occupancy count and synchronous clear.
module pred_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data_c,
    output logic [CNT_W-1:0] count,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_c     = (count_q == '0);
    assign head_data_c = mem_q[head_q];
    assign count       = count_q;

    // Guards keep the pointers coherent even if a caller over/under-runs.
    assign do_push = push & (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty_c;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ret_predict_ctrl.sv
// Return-address prediction controller: drives the RAS on calls/rets, tracks in-flight
// return predictions and raises a one-cycle registered redirect on a wrong prediction.
module ret_predict_ctrl
    import ras_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned QDEPTH     = QDEPTH_DEF,
    parameter int unsigned RET_OFFSET = RET_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_is_call,
    input  logic              fetch_is_ret,
    output logic              fetch_ready,
    output logic              ras_push,
    output logic              ras_pop,
    output logic [ADDR_W-1:0] ras_data,
    input  logic [ADDR_W-1:0] ras_top,
    input  logic              ras_err,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              resolve_valid,
    input  logic              resolve_is_ret,
    input  logic [ADDR_W-1:0] resolve_target,
    input  logic              flush,
    output logic              mispredict,
    output logic [ADDR_W-1:0] mispredict_target,
    output logic              q_err
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic                mispredict_q, mispredict_d;
    logic [ADDR_W-1:0]   mp_tgt_q, mp_tgt_d;
    logic                q_err_q, q_err_d;

    logic                accept_c;
    logic                resolve_ret_c;
    logic                enq_c;
    logic                deq_c;
    logic                mismatch_c;
    logic                clr_c;
    logic [ENT_W-1:0]    enq_data_c;
    logic [ENT_W-1:0]    head_data_c;
    logic [CNT_W-1:0]    count;
    logic                empty_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: recovery lasts exactly one cycle; flush always lands in RUN.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     state_d = mismatch_c ? RECOVER : RUN;
                RECOVER: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        fetch_ready = 1'b0;
        if (!rst && state_q == RUN && count < CNT_W'(QDEPTH)) begin
            fetch_ready = 1'b1;
        end
    end

    // Fetch side: stack commands and return prediction; ret wins over call.
    always_comb begin
        accept_c    = fetch_valid & fetch_ready;
        ras_pop     = accept_c & fetch_is_ret;
        ras_push    = accept_c & fetch_is_call & ~fetch_is_ret;
        ras_data    = fetch_pc + ADDR_W'(RET_OFFSET);
        pred_valid  = ras_pop & ~ras_err;
        pred_target = ras_top;
        enq_data_c  = {ras_top, ~ras_err};
        enq_c       = ras_pop & ~flush;
    end

    // Resolve side: compare the oldest prediction against the executed return.
    always_comb begin
        resolve_ret_c = resolve_valid & resolve_is_ret;
        deq_c         = resolve_ret_c & ~empty_c & ~flush;
        mismatch_c    = deq_c & (~head_data_c[0] |
                                 (head_data_c[ENT_W-1:1] != resolve_target));
        clr_c         = flush | mismatch_c;

        mispredict_d  = mismatch_c;
        mp_tgt_d      = mismatch_c ? resolve_target : mp_tgt_q;
        q_err_d       = q_err_q | (resolve_ret_c & empty_c) | (ras_push & ras_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q <= 1'b0;
            mp_tgt_q     <= '0;
            q_err_q      <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
            mp_tgt_q     <= mp_tgt_d;
            q_err_q      <= q_err_d;
        end
    end

    assign mispredict        = mispredict_q;
    assign mispredict_target = mp_tgt_q;
    assign q_err             = q_err_q;

    pred_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (QDEPTH)
    ) u_pred_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_c),
        .push        (enq_c),
        .push_data   (enq_data_c),
        .pop         (deq_c),
        .head_data_c (head_data_c),
        .count       (count),
        .empty_c     (empty_c)
    );

endmodule

// File: tb/tb_ret_predict_ctrl.sv
// Self-checking bench for ret_predict_ctrl: directed scenarios then random traffic vs a queue model.
module tb_ret_predict_ctrl;

    localparam int unsigned QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        fetch_is_call;
    logic        fetch_is_ret;
    logic        fetch_ready;
    logic        ras_push;
    logic        ras_pop;
    logic [15:0] ras_data;
    logic [15:0] ras_top;
    logic        ras_err;
    logic        pred_valid;
    logic [15:0] pred_target;
    logic        resolve_valid;
    logic        resolve_is_ret;
    logic [15:0] resolve_target;
    logic        flush;
    logic        mispredict;
    logic [15:0] mispredict_target;
    logic        q_err;

    ret_predict_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_is_call     (fetch_is_call),
        .fetch_is_ret      (fetch_is_ret),
        .fetch_ready       (fetch_ready),
        .ras_push          (ras_push),
        .ras_pop           (ras_pop),
        .ras_data          (ras_data),
        .ras_top           (ras_top),
        .ras_err           (ras_err),
        .pred_valid        (pred_valid),
        .pred_target       (pred_target),
        .resolve_valid     (resolve_valid),
        .resolve_is_ret    (resolve_is_ret),
        .resolve_target    (resolve_target),
        .flush             (flush),
        .mispredict        (mispredict),
        .mispredict_target (mispredict_target),
        .q_err             (q_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list of outstanding predictions plus a few flags.
    typedef struct {
        logic [15:0] tgt;
        bit          had;
    } ent_t;

    ent_t        mq[$];
    bit          m_recover = 0;
    bit          m_mp      = 0;
    logic [15:0] m_mpt     = '0;
    bit          m_qerr    = 0;

    task automatic idle();
        fetch_valid    = 0;
        fetch_pc       = '0;
        fetch_is_call  = 0;
        fetch_is_ret   = 0;
        ras_top        = '0;
        ras_err        = 0;
        resolve_valid  = 0;
        resolve_is_ret = 0;
        resolve_target = '0;
        flush          = 0;
    endtask

    // One clock: check combinational outputs, clock, advance model, check registered outputs.
    task automatic step();
        bit          e_ready, e_acc, e_pop, e_push, e_pv, res_ret, mm;
        logic [15:0] e_data;
        ent_t        h;
        #3;
        e_ready = !rst && !m_recover && (mq.size() < QDEPTH);
        e_acc   = fetch_valid && e_ready;
        e_pop   = e_acc && fetch_is_ret;
        e_push  = e_acc && fetch_is_call && !fetch_is_ret;
        e_pv    = e_pop && !ras_err;
        e_data  = 16'((32'(fetch_pc) + 1) % 65536);
        check_eq("fetch_ready", 32'(fetch_ready), 32'(e_ready));
        check_eq("ras_pop", 32'(ras_pop), 32'(e_pop));
        check_eq("ras_push", 32'(ras_push), 32'(e_push));
        check_eq("pred_valid", 32'(pred_valid), 32'(e_pv));
        if (e_push) check_eq("ras_data", 32'(ras_data), 32'(e_data));
        if (e_pv)   check_eq("pred_target", 32'(pred_target), 32'(ras_top));
        @(posedge clk);
        res_ret = resolve_valid && resolve_is_ret;
        if (rst) begin
            mq.delete();
            m_recover = 0; m_mp = 0; m_mpt = '0; m_qerr = 0;
        end else if (flush) begin
            if (res_ret && mq.size() == 0) m_qerr = 1;
            if (e_push && ras_err) m_qerr = 1;
            mq.delete();
            m_recover = 0; m_mp = 0;
        end else begin
            mm = 0;
            if (res_ret) begin
                if (mq.size() == 0) m_qerr = 1;
                else begin
                    h  = mq.pop_front();
                    mm = !h.had || (h.tgt != resolve_target);
                end
            end
            if (e_pop) mq.push_back('{tgt: ras_top, had: !ras_err});
            if (e_push && ras_err) m_qerr = 1;
            if (mm) begin
                mq.delete();
                m_recover = 1; m_mp = 1; m_mpt = resolve_target;
            end else begin
                m_recover = 0; m_mp = 0;
            end
        end
        #1;
        check_eq("mispredict", 32'(mispredict), 32'(m_mp));
        check_eq("mispredict_target", 32'(mispredict_target), 32'(m_mpt));
        check_eq("q_err", 32'(q_err), 32'(m_qerr));
    endtask

    task automatic do_ret(input logic [15:0] top, input bit err);
        idle();
        fetch_valid = 1; fetch_is_ret = 1; fetch_pc = 16'h0050; ras_top = top; ras_err = err;
    endtask

    task automatic do_resolve(input logic [15:0] tgt);
        idle();
        resolve_valid = 1; resolve_is_ret = 1; resolve_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        check_eq("reset_mispredict", 32'(mispredict), 32'd0);
        check_eq("reset_q_err", 32'(q_err), 32'd0);
        rst = 0;

        // Call then matching return
        idle(); fetch_valid = 1; fetch_is_call = 1; fetch_pc = 16'h0100;
        step();
        check_eq("call_data_0101", 32'(ras_data), 32'h0101);
        do_ret(16'h0101, 0); step();
        do_resolve(16'h0101); step();
        check_eq("match_no_mp", 32'(mispredict), 32'd0);

        // Wrong target -> redirect and one-cycle recovery
        do_ret(16'h0200, 0); step();
        do_resolve(16'h0300); step();
        check_eq("mp_pulse", 32'(mispredict), 32'd1);
        check_eq("mp_target_0300", 32'(mispredict_target), 32'h0300);
        idle(); fetch_valid = 1; step();
        check_eq("mp_one_cycle", 32'(mispredict), 32'd0);

        // No prediction available -> always mispredicts
        do_ret(16'h0000, 1); step();
        do_resolve(16'h1234); step();
        check_eq("nopred_mp", 32'(mispredict), 32'd1);
        idle(); step();

        // Queue fills after four returns
        for (int i = 0; i < 4; i++) begin
            do_ret(16'h0400, 0); step();
        end
        #3;
        check_eq("full_ready_low", 32'(fetch_ready), 32'd0);
        resolve_valid = 1; resolve_is_ret = 1; resolve_target = 16'h0400;
        step();
        idle(); fetch_valid = 1; fetch_is_ret = 1; ras_top = 16'h0400;
        step();
        idle(); flush = 1; step();

        // Address wrap and call+ret priority
        idle(); fetch_valid = 1; fetch_is_call = 1; fetch_pc = 16'hFFFF; step();
        check_eq("wrap_data_0000", 32'(ras_data), 32'h0000);
        idle(); fetch_valid = 1; fetch_is_call = 1; fetch_is_ret = 1; ras_top = 16'h0777;
        step();
        idle(); flush = 1; step();

        // Flush beats a mismatching resolve; empty resolve is sticky error
        do_ret(16'h0500, 0); step();
        do_resolve(16'h0600); flush = 1; step();
        check_eq("flush_no_mp", 32'(mispredict), 32'd0);
        do_resolve(16'h0700); step();
        check_eq("empty_q_err", 32'(q_err), 32'd1);
        idle(); step(); step();
        check_eq("q_err_sticky", 32'(q_err), 32'd1);
        rst = 1; step(); rst = 0;
        check_eq("q_err_cleared", 32'(q_err), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst            = ($urandom_range(0, 63) == 0);
            flush          = ($urandom_range(0, 31) == 0);
            fetch_valid    = ($urandom_range(0, 3) != 0);
            fetch_pc       = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            fetch_is_call  = $urandom_range(0, 2) == 0;
            fetch_is_ret   = $urandom_range(0, 1) == 0;
            ras_top        = 16'h0100 + 16'($urandom_range(0, 3));
            ras_err        = ($urandom_range(0, 9) == 0);
            resolve_valid  = $urandom_range(0, 2) == 0;
            resolve_is_ret = $urandom_range(0, 4) != 0;
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) resolve_target = mq[0].tgt;
            else resolve_target = 16'h0100 + 16'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
